// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use bubble, taken-branch flush and dmem wait-state freeze for the 5-stage pipe
module hazard_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             IF_ID_uses_rt,
  input  logic [4:0]       ID_EX_rt,
  input  logic             ID_EX_MemRead,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;
  state_t state, state_nxt;
  logic br_pend, br_pend_nxt;
  logic load_use, do_hold, do_flush, do_bubble, any_branch;
  // Event decode; gated by rst_n so holds drop the instant reset asserts.
  always_comb begin
    load_use   = ID_EX_MemRead && ID_EX_rt != 5'd0 &&
                 (ID_EX_rt == IF_ID_rs || (IF_ID_uses_rt && ID_EX_rt == IF_ID_rt));
    any_branch = branch_taken || (state == MEM_WAIT && br_pend);
    do_hold    = rst_n && ((state == MEM_WAIT) ? !(dmem_req && dmem_ready)
                                               : (dmem_req && !dmem_ready));
    do_flush   = rst_n && !do_hold && any_branch;
    do_bubble  = rst_n && !do_hold && !do_flush && load_use && state != LOAD_STALL;
  end
  always_comb begin
    state_nxt   = do_hold ? MEM_WAIT : do_bubble ? LOAD_STALL : RUN;
    br_pend_nxt = do_hold && any_branch;
  end
  always_comb begin
    PC_write    = !(do_hold || do_bubble);
    IF_ID_write = !(do_hold || do_bubble);
    IF_ID_flush = do_flush;
    ID_EX_flush = do_flush || do_bubble;
    pipe_hold   = do_hold;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      br_pend     <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state   <= state_nxt;
      br_pend <= br_pend_nxt;
      if (!PC_write && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      if (IF_ID_flush && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vector table, reset/saturation sequences and randomized model comparison
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_rt;
  logic IF_ID_uses_rt, ID_EX_MemRead, branch_taken, dmem_req, dmem_ready;
  logic PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_hold;
  logic [15:0] stall_count, flush_count;
  logic s_pc, s_ifw, s_iff, s_ixf, s_hold;
  logic [1:0] s_stall, s_flush;
  logic [4:0] ctrl;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n), .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .IF_ID_uses_rt(IF_ID_uses_rt), .ID_EX_rt(ID_EX_rt), .ID_EX_MemRead(ID_EX_MemRead),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_flush(ID_EX_flush), .pipe_hold(pipe_hold),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_stall_ctrl #(.CNT_W(2)) sat (
    .clk(clk), .rst_n(rst_n), .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .IF_ID_uses_rt(IF_ID_uses_rt), .ID_EX_rt(ID_EX_rt), .ID_EX_MemRead(ID_EX_MemRead),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PC_write(s_pc), .IF_ID_write(s_ifw), .IF_ID_flush(s_iff),
    .ID_EX_flush(s_ixf), .pipe_hold(s_hold),
    .stall_count(s_stall), .flush_count(s_flush)
  );

  assign ctrl = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_hold};

  typedef struct {
    logic [4:0] rs, rt;
    logic       ut;
    logic [4:0] ex_rt;
    logic       mr, br, rq, rd;
    logic [4:0] ctrl;
    int         stall, flush;
  } vec_t;

  vec_t vecs[23];

  // Reference model: pipeline situation tracked as "waiting on memory",
  // "bubble just inserted" and "branch owed after the wait".
  logic m_wait, m_bub, m_pend;
  int m_stall, m_flush;

  function automatic vec_t mk(input logic [4:0] rs, rt, input logic ut, input logic [4:0] ex_rt,
                              input logic mr, br, rq, rd, input logic [4:0] c, input int st, fl);
    vec_t v;
    v.rs = rs; v.rt = rt; v.ut = ut; v.ex_rt = ex_rt; v.mr = mr; v.br = br;
    v.rq = rq; v.rd = rd; v.ctrl = c; v.stall = st; v.flush = fl;
    return v;
  endfunction

  function automatic int sat3(input int x);
    return x > 3 ? 3 : x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    IF_ID_rs = v.rs; IF_ID_rt = v.rt; IF_ID_uses_rt = v.ut; ID_EX_rt = v.ex_rt;
    ID_EX_MemRead = v.mr; branch_taken = v.br; dmem_req = v.rq; dmem_ready = v.rd;
  endtask

  task automatic idle_in();
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  function automatic logic [4:0] model_ctrl();
    logic lu;
    lu = ID_EX_MemRead && ID_EX_rt != 0 &&
         (ID_EX_rt == IF_ID_rs || (IF_ID_uses_rt && ID_EX_rt == IF_ID_rt));
    if (m_wait) begin
      if (!(dmem_req && dmem_ready)) return 5'b00001;
      if (m_pend || branch_taken) return 5'b11110;
      if (lu) return 5'b00010;
      return 5'b11000;
    end
    if (dmem_req && !dmem_ready) return 5'b00001;
    if (branch_taken) return 5'b11110;
    if (lu && !m_bub) return 5'b00010;
    return 5'b11000;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_bub = 0; m_pend = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    model_reset();
    #1;
    chk("reset ctrl", ctrl, 5'b11000);
    chk("reset stall_count", stall_count, 0);
    chk("reset flush_count", flush_count, 0);
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    vecs[0]  = mk(8, 0, 0, 8, 1, 0, 0, 0, 5'b00010, 1, 0);
    vecs[1]  = mk(8, 0, 0, 8, 1, 0, 0, 0, 5'b11000, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 1, 0);
    vecs[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b11000, 1, 0);
    vecs[4]  = mk(3, 8, 0, 8, 1, 0, 0, 0, 5'b11000, 1, 0);
    vecs[5]  = mk(3, 8, 1, 8, 1, 0, 0, 0, 5'b00010, 2, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 2, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 5'b11110, 2, 1);
    vecs[8]  = mk(8, 0, 0, 8, 1, 1, 0, 0, 5'b11110, 2, 2);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 3, 2);
    vecs[10] = mk(0, 0, 0, 0, 0, 1, 1, 0, 5'b00001, 4, 2);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 5, 2);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 1, 5'b11110, 5, 3);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5, 3);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b11000, 5, 3);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 6, 3);
    vecs[16] = mk(8, 0, 0, 8, 1, 0, 1, 1, 5'b00010, 7, 3);
    vecs[17] = mk(8, 0, 0, 8, 1, 0, 0, 0, 5'b11000, 7, 3);
    vecs[18] = mk(8, 0, 0, 8, 1, 0, 0, 0, 5'b00010, 8, 3);
    vecs[19] = mk(0, 0, 0, 0, 0, 1, 0, 0, 5'b11110, 8, 4);
    vecs[20] = mk(8, 0, 0, 8, 1, 0, 0, 0, 5'b00010, 9, 4);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 10, 4);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 1, 1, 5'b11000, 10, 4);

    for (int i = 0; i < 23; i++) begin
      set_in(vecs[i]);
      @(negedge clk);
      chk($sformatf("row%0d ctrl", i), ctrl, vecs[i].ctrl);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d stall_count", i), stall_count, vecs[i].stall);
      chk($sformatf("row%0d flush_count", i), flush_count, vecs[i].flush);
      chk($sformatf("row%0d sat stall", i), s_stall, sat3(vecs[i].stall));
      chk($sformatf("row%0d sat flush", i), s_flush, sat3(vecs[i].flush));
    end

    // Reset asserted while frozen in MEM_WAIT, with the memory still busy.
    set_in(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("pre-reset hold", ctrl, 5'b00001);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-wait reset ctrl", ctrl, 5'b11000);
    chk("mid-wait reset stall_count", stall_count, 0);
    chk("mid-wait reset flush_count", flush_count, 0);
    idle_in();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset idle", ctrl, 5'b11000);
    branch_taken = 1'b1;
    @(negedge clk);
    chk("post-reset branch ctrl", ctrl, 5'b11110);
    @(posedge clk);
    #1;
    chk("post-reset flush_count", flush_count, 1);
    idle_in();

    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] exp_c;
      IF_ID_rs = 5'($urandom_range(0, 3));
      IF_ID_rt = 5'($urandom_range(0, 3));
      ID_EX_rt = 5'($urandom_range(0, 3));
      IF_ID_uses_rt = 1'($urandom);
      ID_EX_MemRead = 1'($urandom);
      branch_taken = ($urandom_range(0, 5) == 0);
      dmem_req = ($urandom_range(0, 4) < 2);
      dmem_ready = 1'($urandom);
      exp_c = model_ctrl();
      @(negedge clk);
      chk($sformatf("rand%0d ctrl", n), ctrl, exp_c);
      @(posedge clk);
      #1;
      m_pend = exp_c[0] ? ((m_wait && m_pend) || branch_taken) : 1'b0;
      m_wait = exp_c[0];
      m_bub = (exp_c == 5'b00010);
      if (!exp_c[4]) m_stall++;
      if (exp_c[2]) m_flush++;
      chk($sformatf("rand%0d stall_count", n), stall_count, m_stall);
      chk($sformatf("rand%0d flush_count", n), flush_count, m_flush);
      chk($sformatf("rand%0d sat stall", n), s_stall, sat3(m_stall));
      chk($sformatf("rand%0d sat flush", n), s_flush, sat3(m_flush));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
